// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, B0, B1, B2, CHECK} state_e;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [3:0] WE_18BIT = 4'b0011;
  localparam int INSTR_W = 18;
endpackage

// File: rtl/prog_loader_timeout.sv
// prog_loader_timeout: inter-byte watchdog, loads on each byte and pulses when it runs out
module prog_loader_timeout #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q;
  // a fresh byte always wins over an expiry landing on the same edge
  assign expire_o = en_i && !load_i && cnt_q == W'(1);
  // reload on every byte, count down while a frame is open
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else if (load_i) cnt_q <= W'(CYCLES);
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads framed UART bytes into the program BRAM while holding the core in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int          ADDR_W         = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic [ADDR_W-1:0]   cpu_address,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [INSTR_W-1:0]  mem_instruction,
  output logic [3:0]          mem_we,
  output logic                proc_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);
  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q, last_q;
  logic [7:0]          chk_q, b1_q;
  logic [1:0]          b0_q;
  logic                inc_q, expire;
  logic [7:0]          chk_sum;
  logic [INSTR_W-1:0]  instr_q;
  logic [3:0]          we_q;
  logic                proc_reset_q, busy_q, done_q, error_q;

  prog_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (rx_valid),
    .en_i     (state_q != IDLE),
    .expire_o (expire)
  );

  assign chk_sum         = chk_q + rx_data;
  assign mem_address     = (busy_q || we_q != 4'b0000) ? addr_q : cpu_address;
  assign mem_instruction = instr_q;
  assign mem_we          = we_q;
  assign proc_reset      = proc_reset_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

  // frame parser, write pipeline and status flags; the final write skips the
  // address increment so a full 1K image never wraps the address back to 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      last_q       <= '0;
      chk_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      inc_q        <= 1'b0;
      instr_q      <= '0;
      we_q         <= '0;
      proc_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q  <= '0;
      inc_q <= 1'b0;
      if (inc_q) addr_q <= addr_q + ADDR_W'(1);
      if (expire) begin
        state_q <= IDLE;
        error_q <= 1'b1;
        busy_q  <= 1'b0;
      end else if (rx_valid) begin
        case (state_q)
          IDLE: if (rx_data == SYNC_BYTE) begin
            state_q      <= LEN_HI;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            proc_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            addr_q       <= '0;
            chk_q        <= '0;
          end
          LEN_HI: begin
            last_q[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
            state_q            <= LEN_LO;
          end
          LEN_LO: begin
            last_q[7:0] <= rx_data;
            state_q     <= B0;
          end
          B0: begin
            b0_q    <= rx_data[1:0];
            chk_q   <= chk_sum;
            state_q <= B1;
          end
          B1: begin
            b1_q    <= rx_data;
            chk_q   <= chk_sum;
            state_q <= B2;
          end
          B2: begin
            instr_q <= {b0_q, b1_q, rx_data};
            we_q    <= WE_18BIT;
            chk_q   <= chk_sum;
            inc_q   <= addr_q != last_q;
            state_q <= addr_q == last_q ? CHECK : B0;
          end
          CHECK: begin
            done_q       <= chk_sum == 8'h00;
            error_q      <= chk_sum != 8'h00;
            proc_reset_q <= chk_sum != 8'h00;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of framing, writes, checksum, timeout and reset
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [9:0]  cpu_address = '0;
  logic [9:0]  mem_address;
  logic [17:0] mem_instruction;
  logic [3:0]  mem_we;
  logic        proc_reset, busy, done, error;
  int checks = 0;
  int failures = 0;
  logic [9:0]  wa[$];
  logic [17:0] wd[$];
  logic [3:0]  ww[$];

  prog_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .cpu_address     (cpu_address),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .mem_we          (mem_we),
    .proc_reset      (proc_reset),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_we !== 4'b0000) begin
      wa.push_back(mem_address);
      wd.push_back(mem_instruction);
      ww.push_back(mem_we);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ww.delete();
  endtask

  task automatic status(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, busy, done, error, proc_reset}, {28'd0, exp});
  endtask

  initial begin
    int bad;
    logic [7:0] sum;
    logic [9:0] i10;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;
    status("reset_flags", 4'b0000);
    chk("reset_we", mem_we, 4'b0000);
    chk("reset_instr", mem_instruction, 18'h0);
    cpu_address = 10'h155; #1;
    chk("idle_mux", mem_address, 10'h155);

    clear_log();
    send(8'hA5);
    status("t1_in_frame", 4'b1001);
    chk("t1_mux_busy", mem_address, 10'h000);
    send(8'h00); send(8'h00); send(8'h02); send(8'h34); send(8'h56);
    send(8'h74);
    status("t1_done", 4'b0100);
    chk("t1_nwrites", wa.size(), 1);
    chk("t1_addr", wa[0], 10'h000);
    chk("t1_data", wd[0], 18'h23456);
    chk("t1_we", ww[0], 4'b0011);

    clear_log();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h03); send(8'hFF); send(8'hFF);
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h01); send(8'h23); send(8'h45);
    send(8'h96);
    status("t2_done", 4'b0100);
    chk("t2_nwrites", wa.size(), 3);
    chk("t2_w0", {wa[0], wd[0]}, {10'h000, 18'h3FFFF});
    chk("t2_w1", {wa[1], wd[1]}, {10'h001, 18'h00000});
    chk("t2_w2", {wa[2], wd[2]}, {10'h002, 18'h12345});
    cpu_address = 10'h2AB; #1;
    chk("t2_mux_cpu", mem_address, 10'h2AB);

    clear_log();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02); send(8'h34); send(8'h56);
    send(8'h75);
    status("t3_bad_chk", 4'b0011);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02); send(8'h34); send(8'h56);
    send(8'h74);
    status("t3_recover", 4'b0100);

    clear_log();
    send(8'h11); send(8'h22);
    status("t4_ignored", 4'b0100);
    chk("t4_no_write", wa.size(), 0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02); send(8'h34);
    repeat (48) @(posedge clk);
    #1;
    status("t4_before_to", 4'b1001);
    @(posedge clk); #1;
    status("t4_timeout", 4'b0011);
    send(8'h00);
    status("t4_idle", 4'b0011);
    chk("t4_no_write2", wa.size(), 0);

    clear_log();
    send(8'hA5); send(8'h00); send(8'h00);
    status("t5_in_frame", 4'b1001);
    #2 reset_n = 1'b0;
    #1;
    status("t5_async", 4'b0000);
    chk("t5_we", mem_we, 4'b0000);
    chk("t5_instr", mem_instruction, 18'h0);
    chk("t5_mux", mem_address, 10'h2AB);
    @(posedge clk); #3 reset_n = 1'b1;
    send(8'h02);
    status("t5_after", 4'b0000);
    chk("t5_no_write", wa.size(), 0);

    clear_log();
    sum = 8'h00;
    send(8'hA5); send(8'h03); send(8'hFF);
    for (int k = 0; k < 1024; k++) begin
      i10 = 10'(k);
      send(8'h00);
      send({6'd0, i10[9:8]});
      send(i10[7:0]);
      sum = sum + {6'd0, i10[9:8]} + i10[7:0];
    end
    status("t6_before_chk", 4'b1001);
    chk("t6_hold_addr", mem_address, 10'h3FF);
    send(8'h00 - sum);
    status("t6_done", 4'b0100);
    chk("t6_nwrites", wa.size(), 1024);
    bad = 0;
    for (int k = 0; k < wa.size(); k++)
      if (wa[k] !== 10'(k) || wd[k] !== 18'(k) || ww[k] !== 4'b0011) bad++;
    chk("t6_sequence", bad, 0);
    chk("t6_last", {wa[1023], wd[1023]}, {10'h3FF, 18'h003FF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
